// File: rtl/utx.sv
// utx: UART transmitter. Frames a byte as start, 8 data bits (LSB first),
// optional parity bit and 1 or 2 stop bits, each CLKS_PER_BIT clocks long.
// Ports:
//   clk    - clock, all state changes on rising edge
//   rstn   - synchronous reset, active-high
//   inbyte - byte to send, latched on the accepting edge
//   load   - transmit request, level-sampled while idle
//   busy   - registered, high while a frame is in progress
//   tx     - registered serial line, idle high
module utx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] inbyte,
    input  logic       load,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bitn, bitn_nxt;
    logic [7:0]         shreg, shreg_nxt;
    logic               tx_nxt, busy_nxt;
    logic               bit_done_c;
    logic               par_bit_c;

    assign bit_done_c = (cnt == CNT_LAST);
    // Even parity is the XOR of the data; odd is its inverse.
    assign par_bit_c  = (^shreg) ^ PAR_ODD;

    // State and datapath registers; tx and busy are registered here too.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bitn  <= bitn_nxt;
            shreg <= shreg_nxt;
            tx    <= tx_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load) state_nxt = S_START;
            S_START:  if (bit_done_c) state_nxt = S_DATA;
            S_DATA:   if (bit_done_c && (bitn == DATA_LAST))
                          state_nxt = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (bit_done_c) state_nxt = S_STOP;
            S_STOP:   if (bit_done_c && (bitn == STOP_LAST)) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of counters, latched byte and registered outputs.
    // tx_nxt is the level of the bit that starts at the coming edge.
    always_comb begin
        cnt_nxt   = bit_done_c ? '0 : cnt + CNT_W'(1);
        bitn_nxt  = bitn;
        shreg_nxt = shreg;
        tx_nxt    = tx;
        busy_nxt  = busy;
        case (state)
            S_IDLE: begin
                cnt_nxt  = '0;
                bitn_nxt = '0;
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (load) begin
                    shreg_nxt = inbyte;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (bit_done_c) begin
                    bitn_nxt = '0;
                    tx_nxt   = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    if (bitn == DATA_LAST) begin
                        bitn_nxt = '0;
                        tx_nxt   = HAS_PAR ? par_bit_c : 1'b1;
                    end else begin
                        bitn_nxt = bitn + BIT_W'(1);
                        tx_nxt   = shreg[bitn + BIT_W'(1)];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done_c) begin
                    bitn_nxt = '0;
                    tx_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    if (bitn == STOP_LAST) begin
                        bitn_nxt = '0;
                        tx_nxt   = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        bitn_nxt = bitn + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_utx.sv
// Bench for utx: four instances with different framing share one stimulus
// stream; a frame-level model per instance predicts tx/busy every cycle.
module tb_utx;

    localparam int N = 4;

    function automatic int cpb_of(input int i);
        case (i)
            0:       return 87;
            default: return 4;
        endcase
    endfunction

    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stp_of(input int i);
        case (i)
            1, 2:    return 2;
            default: return 1;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] inbyte = 8'h00;
    logic       tx_v   [N];
    logic       busy_v [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        utx #(
            .CLKS_PER_BIT(cpb_of(g)),
            .PARITY      (par_of(g)),
            .STOP_BITS   (stp_of(g))
        ) u_dut (
            .clk   (clk),
            .rstn  (rst),
            .inbyte(inbyte),
            .load  (load),
            .busy  (busy_v[g]),
            .tx    (tx_v[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int inst, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, inst, got, want, $time);
        end
    endtask

    // Frame model: a frame is a list of bit levels; tx shows bit (t / C)
    // where t counts edges since the accepting edge.
    function automatic int flen_of(input int i);
        return cpb_of(i) * (10 + ((par_of(i) != 0) ? 1 : 0) + (stp_of(i) - 1));
    endfunction

    function automatic logic [11:0] frame_of(input int i, input logic [7:0] d);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int b = 0; b < 8; b++) f[1+b] = d[b];
        if (par_of(i) == 2) f[9] = ^d;
        if (par_of(i) == 1) f[9] = ~(^d);
        return f;
    endfunction

    logic        live = 1'b0;
    logic        m_act  [N];
    int          m_t    [N];
    logic [11:0] m_bits [N];
    logic        m_tx   [N];
    logic        m_busy [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_tx[i]   <= 1'b1;
                m_busy[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_t[i] + 1 == flen_of(i)) begin
                    m_act[i]  <= 1'b0;
                    m_tx[i]   <= 1'b1;
                    m_busy[i] <= 1'b0;
                end else begin
                    m_tx[i] <= m_bits[i][(m_t[i] + 1) / cpb_of(i)];
                end
                m_t[i] <= m_t[i] + 1;
            end else if (load) begin
                m_act[i]  <= 1'b1;
                m_t[i]    <= 0;
                m_bits[i] <= frame_of(i, inbyte);
                m_tx[i]   <= 1'b0;
                m_busy[i] <= 1'b1;
            end
        end
        if (rst) live <= 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < N; i++) begin
                chk("tx", i, int'(tx_v[i]), int'(m_tx[i]));
                chk("busy", i, int'(busy_v[i]), int'(m_busy[i]));
            end
        end
    end

    // Lengths of the most recent busy-high and busy-low runs per instance.
    int brun [N];
    int irun [N];
    int last_busy [N];
    int last_idle [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            brun[i] = 0; irun[i] = 0; last_busy[i] = 0; last_idle[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (busy_v[i] === 1'b1) begin
                if (irun[i] > 0) last_idle[i] = irun[i];
                irun[i] = 0;
                brun[i] = brun[i] + 1;
            end else begin
                if (brun[i] > 0) last_busy[i] = brun[i];
                brun[i] = 0;
                irun[i] = irun[i] + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Called on the falling edge right after the accepting edge; samples
    // mid-bit and returns on the falling edge after the frame ends.
    task automatic lit_frame(input int inst, input int nb, input logic [11:0] bits,
                             input string nm);
        int c;
        c = cpb_of(inst);
        for (int k = 0; k < nb * c; k++) begin
            if (k % c == c / 2) chk(nm, inst, int'(tx_v[inst]), int'(bits[k / c]));
            step(1);
        end
    endtask

    task automatic accept(input logic [7:0] d);
        inbyte = d;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    initial begin
        logic [11:0] f55, faa, f07e, f07o;
        f55  = 12'b11_1010101010;
        faa  = 12'b11_1101010100;
        f07e = 12'b111000001110;
        f07o = 12'b110000001110;

        do_reset();
        step(1);
        for (int i = 0; i < N; i++) begin
            chk("rst_tx", i, int'(tx_v[i]), 1);
            chk("rst_busy", i, int'(busy_v[i]), 0);
        end

        // 0x55 on default framing, then 0xAA one cycle after busy falls.
        accept(8'h55);
        lit_frame(0, 10, f55, "f55");
        chk("gap_busy", 0, int'(busy_v[0]), 0);
        accept(8'hAA);
        lit_frame(0, 10, faa, "faa");
        step(3);
        chk("len870", 0, last_busy[0], 870);
        chk("gap1", 0, last_idle[0], 1);

        // Load pulse mid-frame with different data is ignored.
        do_reset();
        accept(8'h3C);
        step(99);
        inbyte = 8'hFF;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        step(30);
        chk("ign_bit0", 0, int'(tx_v[0]), 0);
        step(760);
        chk("ign_len", 0, last_busy[0], 870);

        // Reset mid-frame aborts at once; next load runs a clean frame.
        do_reset();
        accept(8'h55);
        step(399);
        rst = 1'b1;
        step(1);
        chk("abort_tx", 0, int'(tx_v[0]), 1);
        chk("abort_busy", 0, int'(busy_v[0]), 0);
        rst = 1'b0;
        accept(8'h0F);
        step(875);
        chk("clean_len", 0, last_busy[0], 870);

        // Parity framing on the short instances.
        do_reset();
        accept(8'h07);
        for (int k = 0; k < 48; k++) begin
            if (k % 4 == 2) begin
                chk("even07", 1, int'(tx_v[1]), int'(f07e[k / 4]));
                chk("odd07", 2, int'(tx_v[2]), int'(f07o[k / 4]));
            end
            step(1);
        end
        step(2);
        chk("len48e", 1, last_busy[1], 48);
        chk("len48o", 2, last_busy[2], 48);
        chk("len40", 3, last_busy[3], 40);

        // load held high: back-to-back frames with one idle cycle between.
        do_reset();
        load = 1'b1;
        for (int k = 0; k < 400; k++) begin
            inbyte = 8'($urandom);
            step(1);
        end
        chk("hold_len", 3, last_busy[3], 40);
        chk("hold_gap", 3, last_idle[3], 1);
        chk("hold_gap48", 1, last_idle[1], 1);
        load = 1'b0;
        step(60);

        // Random traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 30000; k++) begin
            inbyte = 8'($urandom);
            load   = ($urandom_range(0, 99) < 4);
            rst    = ($urandom_range(0, 2999) == 0);
            step(1);
        end
        rst  = 1'b0;
        load = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
